// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan multiplexer: the width helper and the
// encoding of the auto/manual mode input.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int p = 1; p < value; p = p * 2) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/scan_mux_next_enabled.sv
// Finds the first enabled channel strictly after the current one, wrapping
// cyclically; the current channel itself is the last candidate considered.
module next_enabled
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next_idx,
    output logic                found
);

    logic [CHANNELS-1:0] rot_s;
    int                  offset_s;

    // Rotate the mask so bit 0 is the channel after cur, then priority-encode.
    always_comb begin
        rot_s    = '0;
        offset_s = CHANNELS - 1;
        for (int k = 0; k < CHANNELS; k++) begin
            rot_s[k] = mask[(int'(cur) + k + 1) % CHANNELS];
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                offset_s = k;
            end else begin
                offset_s = offset_s;
            end
        end
        next_idx = SEL_W'((int'(cur) + offset_s + 1) % CHANNELS);
        found    = |mask;
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select or dwell-timed
// auto-scan over a channel mask; pulses 'switched' on every channel change.
module scan_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 50000000,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      switched
);

    localparam int              CNT_W    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [SEL_W-1:0] nxt_sel_s;
    logic [SEL_W-1:0] scan_sel_s;
    logic             found_s;
    logic [WIDTH-1:0] sel_data_s;

    next_enabled #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next_enabled (
        .mask     (en_mask),
        .cur      (cur_sel),
        .next_idx (scan_sel_s),
        .found    (found_s)
    );

    // Next select and dwell count; an empty mask freezes the scan entirely.
    always_comb begin
        nxt_sel_s = cur_sel;
        cnt_nxt_s = '0;
        case (auto)
            MODE_MANUAL: begin
                if (int'(sel) < CHANNELS) begin
                    nxt_sel_s = sel;
                end else begin
                    nxt_sel_s = cur_sel;
                end
            end
            MODE_AUTO: begin
                if (!found_s) begin
                    nxt_sel_s = cur_sel;
                    cnt_nxt_s = '0;
                end else if (cnt_r == CNT_LAST) begin
                    nxt_sel_s = scan_sel_s;
                    cnt_nxt_s = '0;
                end else begin
                    nxt_sel_s = cur_sel;
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                nxt_sel_s = cur_sel;
                cnt_nxt_s = '0;
            end
        endcase
    end

    // Data of the channel about to be selected.
    always_comb begin
        sel_data_s = data_in[int'(nxt_sel_s)*WIDTH +: WIDTH];
    end

    // Dwell counter, select and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= '0;
            cur_sel  <= '0;
            data_out <= '0;
            switched <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            cur_sel  <= nxt_sel_s;
            data_out <= sel_data_s;
            switched <= (nxt_sel_s != cur_sel);
        end
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel, W-bit multiplexer for board-level switch/LED datapaths. Operates either in manual mode (select driven directly) or auto-scan mode (dwell timer steps through the channels enabled by a mask). Output data and current select are registered. A one-cycle pulse marks every channel change, so downstream display or capture logic can resynchronise.

## Interface
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 4: number of input channels, ≥2.
- `DWELL`, 50000000: clock cycles spent on each channel in auto mode, ≥1.
- `SEL_W` (localparam): clog2(`CHANNELS`).

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_in` in `CHANNELS*WIDTH`: channel i occupies `[i*WIDTH +: WIDTH]`.
- `sel` in `SEL_W`: manual channel select.
- `auto` in 1: 1 = auto-scan, 0 = manual.
- `en_mask` in `CHANNELS`: bit i = channel i eligible in auto-scan.
- `data_out` out `WIDTH`: registered selected data.
- `cur_sel` out `SEL_W`: registered current channel.
- `switched` out 1: one-cycle pulse, coincident with a new `cur_sel` value.

## Operation
- **Reset (`resetn`=0):**
  - `cur_sel`=0, `data_out`=0, `switched`=0, dwell counter=0.
  - Takes effect immediately; no edge needed.
- **Common update rule:** each edge computes `nxt_sel`, then registers:
  - `cur_sel` <= `nxt_sel`.
  - `data_out` <= `data_in[nxt_sel]`.
  - `switched` <= (`nxt_sel` != `cur_sel`).
- **Manual mode (`auto`=0):**
  - `nxt_sel` = `sel` if `sel` < `CHANNELS`; otherwise `cur_sel` (out-of-range select ignored).
  - Dwell counter held at 0.
- **Auto mode (`auto`=1):**
  - Counter runs 0..`DWELL`-1 and wraps to 0.
  - At terminal count, `nxt_sel` = first enabled channel strictly after `cur_sel`, searching cyclically (`CHANNELS`-1 wraps to 0). Otherwise `nxt_sel` = `cur_sel`.
  - Only `cur_sel` enabled: search returns `cur_sel`; no change, no pulse.
  - `en_mask`=0: `cur_sel` holds, counter held at 0, no pulse.
  - Current channel disabled mid-dwell: it stays selected until terminal count, then advances normally.
  - `DWELL`=1: advance attempted every cycle.
- **Mode transitions:**
  - 0→1: counter starts at 0 on the first auto cycle; scan proceeds from the current `cur_sel`.
  - 1→0: `cur_sel` follows `sel` at the next edge; counter cleared.
- **Data tracking:** `data_out` always tracks `data_in` of the selected channel with 1-cycle latency, even when the select is unchanged.

## Timing
- `sel` change → `cur_sel`, `data_out`, `switched` all update at the next rising edge (latency 1).
- Auto mode, full mask:
  - Each channel is held for exactly `DWELL` cycles.
  - `switched` is high 1 cycle every `DWELL` cycles.
- Simultaneous mask change and terminal count: the search uses the `en_mask` value sampled at that edge.
- No combinational path from any input to any output.

## Structure
- Shared package/header `mux_pkg`:
  - clog2 function.
  - Mode encoding constants `MODE_MANUAL`=0, `MODE_AUTO`=1.
- Sub-module `next_enabled` (combinational):
  - Inputs: `CHANNELS`-bit mask, `SEL_W`-bit current index.
  - Outputs: next enabled index and a `found` flag.
  - Implemented as a rotate + priority encode.
- Top level holds the dwell counter (width clog2(`DWELL`), min 1), select register and output registers.

## Test plan
Configuration: `CHANNELS`=4, `WIDTH`=8, `DWELL`=4, `data_in`={DD,CC,BB,AA} (channel 0 = 8'hAA).

1. **Reset:** assert `resetn`=0 mid-scan with `cur_sel`=2 → `cur_sel`=0, `data_out`=00, `switched`=0 before the next edge; hold 3 cycles, still 0.
2. **Manual select:** `auto`=0, `sel`=2 → next edge `cur_sel`=2, `data_out`=CC, `switched`=1 for one cycle. Then change channel 2 to 8'h5A → `data_out`=5A one cycle later, `switched`=0.
3. **Out-of-range select:** rebuild with `CHANNELS`=3, `cur_sel`=1, `sel`=3 → `cur_sel` stays 1, no pulse.
4. **Auto-scan, full mask:** `auto`=1, `en_mask`=1111 from `cur_sel`=0 → sequence 0,1,2,3,0, each held 4 cycles. `data_out` follows AA,BB,CC,DD,AA; one `switched` pulse per change.
5. **Sparse and empty masks:**
   - `en_mask`=1010 from `cur_sel`=0 → 1,3,1,3 at 4-cycle intervals.
   - `en_mask`=0001 with `cur_sel`=0 → no change, no pulse.
   - `en_mask`=0000 → holds 20 cycles, no pulse.
6. **Mode switch:** auto-scan on channel 2 with `sel`=0, drop `auto` → `cur_sel`=0 at the next edge. Raise `auto` again → first advance to 1 occurs exactly 4 cycles later.
